// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipe stage family.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_BYPASS = 2'd0,
    PIPE_FWD    = 2'd1,
    PIPE_SKID   = 2'd2
  } pipe_mode_e;

  // Level of rst that holds the stage in reset.
  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data holding register. The valid flag is reset, the payload is not.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  // Valid flag: clear wins over load so a flush always empties the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) valid <= 1'b0;
    else if (clear)        valid <= 1'b0;
    else if (load)         valid <= 1'b1;
  end

  // Payload capture; contents are don't-care while valid is low.
  always_ff @(posedge clk) begin
    if (load) data <= load_data;
  end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipe stage: bypass, forward register, or skid buffer, plus flush.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int         DATA_WIDTH   = 32,
  parameter pipe_mode_e MODE         = PIPE_FWD,
  parameter bit         ZERO_INVALID = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  pin_valid,
  input  logic [DATA_WIDTH-1:0] pin_data,
  output logic                  pin_ready,
  output logic                  pout_valid,
  output logic [DATA_WIDTH-1:0] pout_data,
  input  logic                  pout_ready,
  output logic [1:0]            occupancy
);

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  generate
    if (MODE == PIPE_BYPASS) begin : g_bypass
      // Pure wires; a flushed beat is swallowed by forcing ready high.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = pin_valid & ~flush;
      assign out_data  = pin_data;
      assign pin_ready = pout_ready | flush;
      assign occupancy = 2'd0;
    end else if (MODE == PIPE_FWD) begin : g_fwd
      logic                  slot_valid;
      logic [DATA_WIDTH-1:0] slot_data;
      logic                  in_fire, out_fire;

      // Ready looks through to the consumer so a full slot can drain and refill each cycle.
      assign pin_ready = ~slot_valid | pout_ready;
      assign in_fire   = pin_valid & pin_ready;
      assign out_fire  = slot_valid & pout_ready;

      pipe_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (in_fire & ~flush),
        .clear     (flush | (out_fire & ~in_fire)),
        .load_data (pin_data),
        .valid     (slot_valid),
        .data      (slot_data)
      );

      assign out_valid = slot_valid;
      assign out_data  = slot_data;
      assign occupancy = {1'b0, slot_valid};
    end else if (MODE == PIPE_SKID) begin : g_skid
      logic                  main_valid, skid_valid;
      logic [DATA_WIDTH-1:0] main_data, skid_data;
      logic                  in_fire, out_fire;
      logic                  main_load, main_clear, skid_load, skid_clear;

      // Ready comes straight from the skid flag, cutting the combinational pout_ready path.
      assign pin_ready = ~skid_valid;
      assign in_fire   = pin_valid & ~skid_valid;
      assign out_fire  = main_valid & pout_ready;

      // Main refills from skid when it drains, else takes the incoming beat when free.
      assign main_load  = ~flush & ((out_fire & skid_valid) |
                                    (in_fire & (~main_valid | pout_ready)));
      assign main_clear = flush | (out_fire & ~skid_valid & ~in_fire);
      // Skid only catches the one beat that arrives while main is stalled.
      assign skid_load  = ~flush & in_fire & main_valid & ~pout_ready;
      assign skid_clear = flush | (skid_valid & out_fire);

      pipe_slot #(.DATA_WIDTH(DATA_WIDTH)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (skid_valid ? skid_data : pin_data),
        .valid     (main_valid),
        .data      (main_data)
      );

      pipe_slot #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (pin_data),
        .valid     (skid_valid),
        .data      (skid_data)
      );

      assign out_valid = main_valid;
      assign out_data  = main_data;
      assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    end else begin : g_bad_mode
      $error("pipe_stage: unsupported MODE value");
    end
  endgenerate

  assign pout_valid = out_valid;
  assign pout_data  = (ZERO_INVALID && !out_valid) ? '0 : out_data;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed vectors and random scoreboard for all three pipe_stage modes.
module tb_pipe_stage;
  import pipe_pkg::*;

  localparam int NB = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl   [3];
  logic        pv   [3];
  logic        prdy [3];
  logic        rdy  [3];
  logic        vld  [3];
  logic [31:0] pd   [3];
  logic [31:0] dat  [3];
  logic [1:0]  occ  [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage #(.DATA_WIDTH(32), .MODE(PIPE_BYPASS), .ZERO_INVALID(1'b1)) u_byp (
    .clk(clk), .rst(rst), .flush(fl[0]), .pin_valid(pv[0]), .pin_data(pd[0]),
    .pin_ready(rdy[0]), .pout_valid(vld[0]), .pout_data(dat[0]),
    .pout_ready(prdy[0]), .occupancy(occ[0]));

  pipe_stage #(.DATA_WIDTH(32), .MODE(PIPE_FWD), .ZERO_INVALID(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .flush(fl[1]), .pin_valid(pv[1]), .pin_data(pd[1]),
    .pin_ready(rdy[1]), .pout_valid(vld[1]), .pout_data(dat[1]),
    .pout_ready(prdy[1]), .occupancy(occ[1]));

  pipe_stage #(.DATA_WIDTH(32), .MODE(PIPE_SKID), .ZERO_INVALID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(fl[2]), .pin_valid(pv[2]), .pin_data(pd[2]),
    .pin_ready(rdy[2]), .pout_valid(vld[2]), .pout_data(dat[2]),
    .pout_ready(prdy[2]), .occupancy(occ[2]));

  typedef struct {
    int          m;
    logic        r;
    logic        f;
    logic        v;
    logic [31:0] d;
    logic        pr;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int m, logic r, logic f, logic v, logic [31:0] d, logic pr,
                              logic er, logic ev, logic [31:0] ed, logic [1:0] eo);
    vec_t x;
    x.m = m; x.r = r; x.f = f; x.v = v; x.d = d; x.pr = pr;
    x.e_rdy = er; x.e_vld = ev; x.e_dat = ed; x.e_occ = eo;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      fl[k] = 1'b0; pv[k] = 1'b0; pd[k] = '0; prdy[k] = 1'b0;
    end
  endtask

  // Hard stop if anything stalls far beyond the expected run length.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sb[$];
    logic [31:0] exp_d, prev_dat;
    logic        in_fire, out_fire, in_fire_prev, stall_prev, r0, old_pr;
    int          sent, recv, cyc, m;

    rst = 1'b0;
    idle();

    // ---- directed table ----
    // reset state (args: mode, rst, flush, pin_valid, pin_data, pout_ready | ready, valid, data, occ)
    add(0,0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0,1, 1,0,0,0);
    add(1,0,0,0,0,0, 1,0,0,0);
    add(2,0,0,0,0,0, 1,0,0,0);
    // bypass: pass-through, flush swallows
    add(0,1,0,1,32'h55,0, 0,1,32'h55,0);
    add(0,1,1,1,32'h66,0, 1,0,0,0);
    add(0,1,0,0,32'h77,1, 1,0,0,0);
    // streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) add(0,1,0,1,i,1, 1,1,i,0);
    add(0,1,0,0,0,1, 1,0,0,0);
    for (int k = 1; k <= 2; k++) begin
      for (int i = 1; i <= 8; i++) add(k,1,0,1,i,1, 1,(i>1),(i>1)?i-1:0,(i>1)?2'd1:2'd0);
      add(k,1,0,0,0,1, 1,1,8,1);
      add(k,1,0,0,0,1, 1,0,0,0);
    end
    // FWD backpressure: ready drops with slot full, A5 held
    add(1,1,0,1,32'hA5,0, 1,0,0,0);
    add(1,1,0,1,32'hB6,0, 0,1,32'hA5,1);
    add(1,1,0,1,32'hB6,0, 0,1,32'hA5,1);
    add(1,1,0,1,32'hB6,1, 1,1,32'hA5,1);
    add(1,1,0,0,0,1,      1,1,32'hB6,1);
    add(1,1,0,0,0,0,      1,0,0,0);
    // FWD flush: held beat and an accepted beat both discarded
    add(1,1,0,1,32'hC1,0, 1,0,0,0);
    add(1,1,1,1,32'h99,0, 0,1,32'hC1,1);
    add(1,1,0,0,0,1,      1,0,0,0);
    add(1,1,1,1,32'h99,1, 1,0,0,0);
    add(1,1,0,0,0,1,      1,0,0,0);
    // FWD async reset mid-transfer
    add(1,1,0,1,32'hDEADBEEF,0, 1,0,0,0);
    add(1,0,0,1,32'hDEADBEEF,0, 1,0,0,0);
    add(1,1,0,0,0,0,            1,0,0,0);
    // SKID backpressure: 3 stalled cycles, skid fills, order preserved
    add(2,1,0,1,32'h10,1, 1,0,0,0);
    add(2,1,0,1,32'h11,0, 1,1,32'h10,1);
    add(2,1,0,1,32'h12,0, 0,1,32'h10,2);
    add(2,1,0,1,32'h12,0, 0,1,32'h10,2);
    add(2,1,0,1,32'h12,1, 0,1,32'h10,2);
    add(2,1,0,1,32'h12,1, 1,1,32'h11,1);
    add(2,1,0,0,0,1,      1,1,32'h12,1);
    add(2,1,0,0,0,1,      1,0,0,0);
    // SKID flush with both slots full and 0x99 offered
    add(2,1,0,1,32'h20,0, 1,0,0,0);
    add(2,1,0,1,32'h21,0, 1,1,32'h20,1);
    add(2,1,1,1,32'h99,0, 0,1,32'h20,2);
    add(2,1,0,0,0,1,      1,0,0,0);
    add(2,1,1,1,32'h99,1, 1,0,0,0);
    add(2,1,0,0,0,1,      1,0,0,0);
    add(2,1,0,1,32'h30,1, 1,0,0,0);
    add(2,1,1,1,32'h99,1, 1,1,32'h30,1);
    add(2,1,0,0,0,1,      1,0,0,0);
    // SKID async reset with occupancy 2
    add(2,1,0,1,32'hDEADBEEF,0, 1,0,0,0);
    add(2,1,0,1,32'hCAFEF00D,0, 1,1,32'hDEADBEEF,1);
    add(2,0,0,1,32'hCAFEF00D,0, 1,0,0,0);
    add(2,1,0,0,0,0,            1,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      idle();
      m       = tbl[i].m;
      rst     = tbl[i].r;
      fl[m]   = tbl[i].f;
      pv[m]   = tbl[i].v;
      pd[m]   = tbl[i].d;
      prdy[m] = tbl[i].pr;
      #1;
      chk($sformatf("v%0d_m%0d_pin_ready", i, m), rdy[m], tbl[i].e_rdy);
      chk($sformatf("v%0d_m%0d_pout_valid", i, m), vld[m], tbl[i].e_vld);
      chk($sformatf("v%0d_m%0d_pout_data", i, m), dat[m], tbl[i].e_dat);
      chk($sformatf("v%0d_m%0d_occupancy", i, m), occ[m], tbl[i].e_occ);
    end

    @(negedge clk);
    idle();
    rst = 1'b1;

    // ---- random valid/ready with scoreboard, one mode at a time ----
    for (int mm = 0; mm < 3; mm++) begin
      sb.delete();
      sent = 0; recv = 0; cyc = 0;
      in_fire_prev = 1'b0; stall_prev = 1'b0; prev_dat = '0;
      while (recv < NB && cyc < 25000) begin
        @(negedge clk);
        cyc++;
        if (in_fire_prev) pv[mm] = 1'b0;
        if (!pv[mm] && sent < NB && $urandom_range(3) != 0) begin
          pd[mm] = $urandom;
          pv[mm] = 1'b1;
          sent++;
        end
        prdy[mm] = ($urandom_range(3) != 0);
        #1;
        if (stall_prev) begin
          chk($sformatf("m%0d_stall_valid", mm), vld[mm], 1'b1);
          chk($sformatf("m%0d_stall_data", mm), dat[mm], prev_dat);
        end
        if (mm == 2) begin
          r0 = rdy[mm];
          old_pr = prdy[mm];
          prdy[mm] = ~old_pr;
          #1;
          chk("skid_ready_indep", rdy[mm], r0);
          prdy[mm] = old_pr;
          #1;
        end
        in_fire  = pv[mm] & rdy[mm];
        out_fire = vld[mm] & prdy[mm];
        if (in_fire) sb.push_back(pd[mm]);
        if (out_fire) begin
          if (sb.size() == 0) begin
            chk($sformatf("m%0d_spurious_beat", mm), 1'b1, 1'b0);
          end else begin
            exp_d = sb.pop_front();
            chk($sformatf("m%0d_beat%0d", mm, recv), dat[mm], exp_d);
          end
          recv++;
        end
        in_fire_prev = in_fire;
        stall_prev   = vld[mm] & ~prdy[mm];
        prev_dat     = dat[mm];
      end
      chk($sformatf("m%0d_beats_received", mm), recv, NB);
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("m%0d_drained_occ", mm), occ[mm], 2'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
